// File: rtl/adder_pkg.sv
// adder_pkg
// Shared types and helpers for the pipelined carry-skip adder.
//   gpk_e     : per-bit carry class produced by gpk_cell
//   sat_value : saturation constant for a given sign and operand width
package adder_pkg;

  // Carry class of one bit position. Exactly one applies per bit.
  typedef enum logic [2:0] {
    KILL = 3'b000,
    GEN  = 3'b001,
    PROP = 3'b010
  } gpk_e;

  // Returns the saturation limit in the low 'width' bits:
  // sign=0 -> largest positive value, sign=1 -> most negative value.
  // The caller keeps only the bits it needs.
  function automatic logic [63:0] sat_value(input logic sign, input int unsigned width);
    logic [63:0] msbOnly;
    msbOnly = 64'd1 << (width - 1);
    if (sign) begin
      return msbOnly;
    end
    return msbOnly - 64'd1;
  endfunction

endpackage

// File: rtl/carry_skip_adder_pipe_gpk_cell.sv
// gpk_cell
// Classifies one bit pair of an addition into generate, propagate or kill.
// Ports:
//   a_i   : operand A bit
//   b_i   : operand B bit (already inverted for subtraction)
//   cls_o : carry class of this bit position
module gpk_cell
  import adder_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  output gpk_e cls_o
);

  // Generate wins over propagate; a bit pair that does neither kills the
  // carry. The checks are mutually exclusive, so the order only documents
  // intent.
  always_comb begin
    cls_o = KILL;
    if (a_i & b_i) begin
      cls_o = GEN;
    end else if (a_i ^ b_i) begin
      cls_o = PROP;
    end
  end

endmodule

// File: rtl/carry_skip_adder_pipe.sv
// carry_skip_adder_pipe
// Two-stage pipelined signed carry-skip adder/subtractor with valid/ready
// streams on both sides. Stage 1 registers operands and per-bit / per-group
// carry classes; stage 2 ripples inside each group, lets a fully propagating
// group pass its incoming carry straight through, and registers the result.
// Optional feature: define CARRY_SKIP_SAT_EN to saturate sum_o on signed
// overflow (ovf_o and cout_o still report the raw result).
// Ports:
//   clk_i, rst_i              : clock, asynchronous active-high reset
//   in_valid_i / in_ready_o   : operand beat handshake
//   a_i, b_i                  : signed operands
//   sub_i                     : 1 = A-B, 0 = A+B+cin_i
//   cin_i                     : carry-in, ignored when subtracting
//   out_valid_o / out_ready_i : result handshake
//   sum_o, cout_o, ovf_o      : result, carry out of MSB, signed overflow
module carry_skip_adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  input  logic             cin_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int NGROUPS = WIDTH / BLOCK;

  if ((BLOCK < 1) || (BLOCK > WIDTH) || ((WIDTH % BLOCK) != 0)) begin : gen_param_check
    $error("carry_skip_adder_pipe: WIDTH must be a non-zero multiple of BLOCK");
  end

  logic [WIDTH-1:0]   bEff;
  logic               cinEff;
  gpk_e               cls [WIDTH];
  logic [WIDTH-1:0]   genD, propD;
  logic [NGROUPS-1:0] pgD;

  logic               s1Valid_q;
  logic [WIDTH-1:0]   a_q, b_q, gen_q, prop_q;
  logic               cin_q;
  logic [NGROUPS-1:0] pg_q;

  logic [WIDTH:0]     carry;
  logic [WIDTH-1:0]   sum_d;
  logic               cout_d, ovf_d;
  logic               outValid_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q, ovf_q;

  logic               adv2, accept;

  // Subtraction is A + ~B + 1, so B is inverted and the carry-in forced high.
  assign bEff   = b_i ^ {WIDTH{sub_i}};
  assign cinEff = sub_i | cin_i;

  for (genvar i = 0; i < WIDTH; i++) begin : gen_cells
    gpk_cell u_cell (
      .a_i   (a_i[i]),
      .b_i   (bEff[i]),
      .cls_o (cls[i])
    );
  end

  // Flatten the per-bit classes into generate/propagate vectors and build the
  // group-propagate flags that let a carry jump over a whole group.
  always_comb begin
    genD  = '0;
    propD = '0;
    pgD   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      genD[i]  = (cls[i] == GEN);
      propD[i] = (cls[i] == PROP);
    end
    for (int g = 0; g < NGROUPS; g++) begin
      pgD[g] = &propD[g*BLOCK +: BLOCK];
    end
  end

  // The output stage moves whenever it is empty or being drained; the input
  // stage can take a beat whenever it is empty or about to move on, which
  // lets bubbles collapse and keeps full rate with a ready consumer.
  assign adv2       = ~outValid_q | out_ready_i;
  assign in_ready_o = ~s1Valid_q | adv2;
  assign accept     = in_valid_i & in_ready_o;

  // Stage 1 register: operands, effective carry-in and carry classes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1Valid_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      cin_q     <= 1'b0;
      gen_q     <= '0;
      prop_q    <= '0;
      pg_q      <= '0;
    end else begin
      if (in_ready_o) begin
        s1Valid_q <= in_valid_i;
      end
      if (accept) begin
        a_q    <= a_i;
        b_q    <= bEff;
        cin_q  <= cinEff;
        gen_q  <= genD;
        prop_q <= propD;
        pg_q   <= pgD;
      end
    end
  end

  // Ripple within each group. At a group boundary a fully propagating group
  // hands on the carry it received; that is the same value the ripple would
  // produce, only through a shorter path.
  always_comb begin
    carry    = '0;
    carry[0] = cin_q;
    for (int g = 0; g < NGROUPS; g++) begin
      for (int j = 0; j < BLOCK; j++) begin
        carry[g*BLOCK+j+1] = gen_q[g*BLOCK+j] | (prop_q[g*BLOCK+j] & carry[g*BLOCK+j]);
      end
      if (pg_q[g]) begin
        carry[(g+1)*BLOCK] = carry[g*BLOCK];
      end
    end
  end

  // Result assembly. Signed overflow is a mismatch between the carries into
  // and out of the sign bit; when saturating, the operand sign gives the
  // direction since both operands share it whenever overflow happens.
`ifdef CARRY_SKIP_SAT_EN
  logic [63:0] satWide;
  always_comb begin
    cout_d  = carry[WIDTH];
    ovf_d   = carry[WIDTH] ^ carry[WIDTH-1];
    satWide = sat_value(a_q[WIDTH-1], WIDTH);
    sum_d   = a_q ^ b_q ^ carry[WIDTH-1:0];
    if (ovf_d) begin
      sum_d = satWide[WIDTH-1:0];
    end
  end
`else
  always_comb begin
    cout_d = carry[WIDTH];
    ovf_d  = carry[WIDTH] ^ carry[WIDTH-1];
    sum_d  = a_q ^ b_q ^ carry[WIDTH-1:0];
  end
`endif

  // Stage 2 / output register. Holds its contents while the consumer stalls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outValid_q <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (adv2) begin
      outValid_q <= s1Valid_q;
      if (s1Valid_q) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign out_valid_o = outValid_q;
  assign sum_o       = sum_q;
  assign cout_o      = cout_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_carry_skip_adder_pipe.sv
// tb_carry_skip_adder_pipe
// Directed bench for carry_skip_adder_pipe at WIDTH=16, BLOCK=4: a vector
// table of single beats with hand-computed results and latency check, a
// back-pressure stream, and an asynchronous reset with beats in flight.
module tb_carry_skip_adder_pipe;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
    logic [15:0] sumWrap;
    logic [15:0] sumSat;
    logic        cout;
    logic        ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        inValid;
  logic        inReady;
  logic [15:0] a, b;
  logic        sub, cin;
  logic        outValid;
  logic        outReady;
  logic [15:0] sum;
  logic        cout, ovf;

  int tests    = 0;
  int failures = 0;

  vec_t vecs [13];

  carry_skip_adder_pipe #(.WIDTH(16), .BLOCK(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (inValid),
    .in_ready_o  (inReady),
    .a_i         (a),
    .b_i         (b),
    .sub_i       (sub),
    .cin_i       (cin),
    .out_valid_o (outValid),
    .out_ready_i (outReady),
    .sum_o       (sum),
    .cout_o      (cout),
    .ovf_o       (ovf)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // One comparison: bumps the counters and reports any difference.
  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Presents one beat for one cycle with a ready consumer and checks that the
  // result shows up exactly two edges after acceptance with the right values.
  task automatic applyStimulus(input int idx);
    logic [15:0] expSum;
`ifdef CARRY_SKIP_SAT_EN
    expSum = vecs[idx].sumSat;
`else
    expSum = vecs[idx].sumWrap;
`endif
    @(negedge clk);
    a        = vecs[idx].a;
    b        = vecs[idx].b;
    sub      = vecs[idx].sub;
    cin      = vecs[idx].cin;
    inValid  = 1'b1;
    outReady = 1'b1;
    #1;
    checkOutput($sformatf("vec%0d in_ready", idx), {15'd0, inReady}, 16'd1);
    @(negedge clk);
    inValid = 1'b0;
    checkOutput($sformatf("vec%0d valid after 1 edge", idx), {15'd0, outValid}, 16'd0);
    @(negedge clk);
    checkOutput($sformatf("vec%0d valid after 2 edges", idx), {15'd0, outValid}, 16'd1);
    checkOutput($sformatf("vec%0d sum", idx), sum, expSum);
    checkOutput($sformatf("vec%0d cout", idx), {15'd0, cout}, {15'd0, vecs[idx].cout});
    checkOutput($sformatf("vec%0d ovf", idx), {15'd0, ovf}, {15'd0, vecs[idx].ovf});
  endtask

  initial begin
    logic [15:0] expQ [$];
    logic [15:0] streamA [4];
    int          sent;
    int          received;
    logic        acc;
    logic        del;
    logic        staleSeen;

    //            a        b        sub   cin   wrap     sat      cout  ovf
    vecs[0]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 16'h7FFF, 1'b0, 1'b1};
    vecs[1]  = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 16'h8000, 1'b1, 1'b1};
    vecs[2]  = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 16'h1000, 1'b0, 1'b0};
    vecs[3]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[4]  = '{16'h1234, 16'h0001, 1'b0, 1'b1, 16'h1236, 16'h1236, 1'b0, 1'b0};
    vecs[5]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 16'h8000, 1'b1, 1'b1};
    vecs[6]  = '{16'h0000, 16'h8000, 1'b1, 1'b0, 16'h8000, 16'h7FFF, 1'b0, 1'b1};
    vecs[7]  = '{16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[8]  = '{16'h0005, 16'h0003, 1'b1, 1'b0, 16'h0002, 16'h0002, 1'b1, 1'b0};
    vecs[9]  = '{16'h0003, 16'h0005, 1'b1, 1'b0, 16'hFFFE, 16'hFFFE, 1'b0, 1'b0};
    vecs[10] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 16'h000F, 1'b1, 1'b0};
    vecs[11] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0};
    vecs[12] = '{16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 16'hFFFE, 16'h7FFF, 1'b0, 1'b1};

    rst      = 1'b1;
    inValid  = 1'b0;
    outReady = 1'b0;
    a        = '0;
    b        = '0;
    sub      = 1'b0;
    cin      = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset out_valid", {15'd0, outValid}, 16'd0);
    checkOutput("reset sum", sum, 16'h0000);
    checkOutput("reset cout", {15'd0, cout}, 16'd0);
    checkOutput("reset ovf", {15'd0, ovf}, 16'd0);
    checkOutput("reset in_ready", {15'd0, inReady}, 16'd1);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(i);
    end

    // Back-pressure stream: the consumer stalls for the first four cycles,
    // so only two beats fit before in_ready drops; then everything drains.
    for (int i = 0; i < 4; i++) begin
      streamA[i] = 16'h0111 * (i + 1);
      expQ.push_back(streamA[i] + 16'h0001);
    end
    sent     = 0;
    received = 0;
    sub      = 1'b0;
    cin      = 1'b0;
    for (int cyc = 0; cyc < 60 && received < 4; cyc++) begin
      @(negedge clk);
      outReady = (cyc >= 4);
      inValid  = (sent < 4);
      a        = streamA[sent < 4 ? sent : 3];
      b        = 16'h0001;
      #1;
      if (cyc == 3) begin
        checkOutput("stall accepted count", 16'(sent), 16'd2);
        checkOutput("stall in_ready", {15'd0, inReady}, 16'd0);
        checkOutput("stall out_valid", {15'd0, outValid}, 16'd1);
        checkOutput("stall held sum", sum, expQ[0]);
      end
      acc = inValid & inReady;
      del = outValid & outReady;
      if (del) begin
        checkOutput($sformatf("stream result %0d", received), sum, expQ[received]);
        received++;
      end
      @(posedge clk);
      if (acc) begin
        sent++;
      end
    end
    checkOutput("stream all delivered", 16'(received), 16'd4);

    // Asynchronous reset with two beats in flight and a stalled consumer.
    @(negedge clk);
    inValid  = 1'b0;
    outReady = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      a       = 16'h0100 + 16'(i);
      b       = 16'h0020;
      inValid = 1'b1;
    end
    @(negedge clk);
    inValid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async reset out_valid", {15'd0, outValid}, 16'd0);
    checkOutput("async reset sum", sum, 16'h0000);
    checkOutput("async reset cout/ovf", {14'd0, cout, ovf}, 16'd0);
    @(negedge clk);
    rst      = 1'b0;
    outReady = 1'b1;
    staleSeen = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (outValid) begin
        staleSeen = 1'b1;
      end
    end
    checkOutput("no stale result after reset", {15'd0, staleSeen}, 16'd0);
    checkOutput("in_ready after reset", {15'd0, inReady}, 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
